hazard_mc: RTL and testbench

- Parametrised next-generation hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W), sitting beside the datapath/controller.
- Keeps the existing behaviour: E-stage forwarding, D-stage branch forwarding, load-use stall and branch stall.
- Adds JR stall, HI/LO tracking for a multi-cycle multiply/divide unit (per-op busy counter), and a saturating stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 10 +
 rtl/hazard_mc_if.sv | 34 +++
 rtl/hazard_mc_md_busy_counter.sv | 34 +++
 rtl/hazard_mc.sv | 78 +++++++
 tb/tb_hazard_mc.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard unit: forward-select encodings and default widths.
package hazard_pkg;

    localparam int REG_W_DEFAULT = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_mc_if.sv
// Datapath <-> hazard unit signal bundle; master is the pipeline side, slave the hazard unit.
interface hazard_mc_if import hazard_pkg::*; #(
    parameter int REG_W = REG_W_DEFAULT,
    parameter int CNT_W = 16
) ();

    logic             BranchD, JrD;
    logic [REG_W-1:0] RsD, RtD, RsE, RtE;
    logic [REG_W-1:0] WriteRegE, WriteRegM, WriteRegW;
    logic             MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW;
    logic             MdStartE, MdDivE, MdUseD, ClrCount;
    logic             StallF, StallD, FlushE;
    logic             ForwardAD, ForwardBD;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             MdBusy;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output BranchD, JrD, RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW,
               MdStartE, MdDivE, MdUseD, ClrCount,
        input  StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
               MdBusy, StallCount
    );

    modport slave (
        input  BranchD, JrD, RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW,
               MdStartE, MdDivE, MdUseD, ClrCount,
        output StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
               MdBusy, StallCount
    );

endinterface

// File: rtl/hazard_mc_md_busy_counter.sv
// Tracks how many cycles remain until HI/LO is valid after a mult/div issues from E.
module md_busy_counter import hazard_pkg::*; #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    localparam logic [CW-1:0] MULT_LD = CW'(MULT_LAT);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_LAT);

    logic [CW-1:0] r_mdcnt;

    // A new start restarts the count even if a previous op is still in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mdcnt <= '0;
        end else if (start) begin
            r_mdcnt <= div ? DIV_LD : MULT_LD;
        end else if (r_mdcnt != '0) begin
            r_mdcnt <= r_mdcnt - CW'(1);
        end
    end

    assign busy = !reset && (start || (r_mdcnt != '0));

endmodule

// File: rtl/hazard_mc.sv
// Hazard unit for the 5-stage pipeline: forwarding selects, stall/flush generation,
// HI/LO busy tracking and a saturating stall-cycle counter.
module hazard_mc import hazard_pkg::*; #(
    parameter int REG_W    = REG_W_DEFAULT,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       reset,
    hazard_mc_if.slave hz
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Register 0 is hardwired, so it never produces a hazard or forward
    function automatic logic hit(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
        return (dst != '0) && (dst == src);
    endfunction

    logic             w_busy;
    logic             w_lwstall, w_brstall, w_jrstall, w_mdstall, w_stall;
    logic [1:0]       w_fwd_ae, w_fwd_be;
    logic [CNT_W-1:0] r_stall_cnt;

    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy (
        .clk   (clk),
        .reset (reset),
        .start (hz.MdStartE),
        .div   (hz.MdDivE),
        .busy  (w_busy)
    );

    assign w_lwstall = hz.MemtoRegE &&
                       (hit(hz.WriteRegE, hz.RsD) || hit(hz.WriteRegE, hz.RtD));
    assign w_brstall = hz.BranchD &&
                       ((hz.RegWriteE && (hit(hz.WriteRegE, hz.RsD) || hit(hz.WriteRegE, hz.RtD))) ||
                        (hz.MemtoRegM && (hit(hz.WriteRegM, hz.RsD) || hit(hz.WriteRegM, hz.RtD))));
    assign w_jrstall = hz.JrD &&
                       ((hz.RegWriteE && hit(hz.WriteRegE, hz.RsD)) ||
                        (hz.MemtoRegM && hit(hz.WriteRegM, hz.RsD)));
    assign w_mdstall = hz.MdUseD && w_busy;
    assign w_stall   = !reset && (w_lwstall || w_brstall || w_jrstall || w_mdstall);

    always_comb begin
        w_fwd_ae = FWD_RF;
        w_fwd_be = FWD_RF;
        if (!reset) begin
            if (hz.RegWriteM && hit(hz.WriteRegM, hz.RsE))      w_fwd_ae = FWD_MEM;
            else if (hz.RegWriteW && hit(hz.WriteRegW, hz.RsE)) w_fwd_ae = FWD_WB;
            if (hz.RegWriteM && hit(hz.WriteRegM, hz.RtE))      w_fwd_be = FWD_MEM;
            else if (hz.RegWriteW && hit(hz.WriteRegW, hz.RtE)) w_fwd_be = FWD_WB;
        end
    end

    // Clear wins over increment; the count sticks at all-ones
    always_ff @(posedge clk) begin
        if (reset || hz.ClrCount) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign hz.StallF     = w_stall;
    assign hz.StallD     = w_stall;
    assign hz.FlushE     = w_stall;
    assign hz.ForwardAD  = !reset && hz.RegWriteM && hit(hz.WriteRegM, hz.RsD);
    assign hz.ForwardBD  = !reset && hz.RegWriteM && hit(hz.WriteRegM, hz.RtD);
    assign hz.ForwardAE  = w_fwd_ae;
    assign hz.ForwardBE  = w_fwd_be;
    assign hz.MdBusy     = w_busy;
    assign hz.StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_mc.sv
// Scoreboarded bench for hazard_mc: directed scenarios followed by random traffic, checked
// against a cycle-number reference model.
module tb_hazard_mc;

    localparam int REG_W    = 5;
    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 32;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef struct {
        int stall;
        int fad, fbd;
        int fae, fbe;
        int busy;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    hazard_mc_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

    hazard_mc #(
        .REG_W    (REG_W),
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   md_ready = 0;
    int   m_cnt = 0;
    int   stall_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int hitm(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
        return (dst != 0 && dst == src) ? 1 : 0;
    endfunction

    function automatic int fwd(input logic [REG_W-1:0] src);
        if (hz.RegWriteM && hitm(hz.WriteRegM, src) != 0) return 2;
        if (hz.RegWriteW && hitm(hz.WriteRegW, src) != 0) return 1;
        return 0;
    endfunction

    // Busy is expressed as "current cycle precedes the cycle HI/LO becomes valid"
    task automatic step();
        exp_t e;
        int   lw, br, jr, md;
        e = '{default: 0};
        e.cnt = m_cnt;
        if (!reset) begin
            e.busy = (hz.MdStartE || cyc < md_ready) ? 1 : 0;
            lw = hz.MemtoRegE && (hitm(hz.WriteRegE, hz.RsD) + hitm(hz.WriteRegE, hz.RtD) > 0);
            br = hz.BranchD &&
                 ((hz.RegWriteE && (hitm(hz.WriteRegE, hz.RsD) + hitm(hz.WriteRegE, hz.RtD) > 0)) ||
                  (hz.MemtoRegM && (hitm(hz.WriteRegM, hz.RsD) + hitm(hz.WriteRegM, hz.RtD) > 0)));
            jr = hz.JrD && ((hz.RegWriteE && hitm(hz.WriteRegE, hz.RsD) != 0) ||
                            (hz.MemtoRegM && hitm(hz.WriteRegM, hz.RsD) != 0));
            md = hz.MdUseD && e.busy != 0;
            e.stall = (lw || br || jr || md) ? 1 : 0;
            e.fad = (hz.RegWriteM && hitm(hz.WriteRegM, hz.RsD) != 0) ? 1 : 0;
            e.fbd = (hz.RegWriteM && hitm(hz.WriteRegM, hz.RtD) != 0) ? 1 : 0;
            e.fae = fwd(hz.RsE);
            e.fbe = fwd(hz.RtE);
        end
        q.push_back(e);
        @(posedge clk);
        if (reset) begin
            md_ready = 0;
            m_cnt    = 0;
        end else begin
            if (hz.MdStartE) md_ready = cyc + (hz.MdDivE ? DIV_LAT : MULT_LAT) + 1;
            if (hz.ClrCount) m_cnt = 0;
            else if (e.stall != 0 && m_cnt < CNT_MAX) m_cnt++;
        end
        cyc++;
        #1;
    endtask

    task automatic clear_inputs();
        hz.BranchD = 0; hz.JrD = 0;
        hz.RsD = 0; hz.RtD = 0; hz.RsE = 0; hz.RtE = 0;
        hz.WriteRegE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
        hz.MemtoRegE = 0; hz.RegWriteE = 0; hz.MemtoRegM = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
        hz.MdStartE = 0; hz.MdDivE = 0; hz.MdUseD = 0; hz.ClrCount = 0;
    endtask

    function automatic logic [REG_W-1:0] rreg();
        return REG_W'($urandom_range(0, 3));
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("StallF",     hz.StallF,     e.stall);
            chk("StallD",     hz.StallD,     e.stall);
            chk("FlushE",     hz.FlushE,     e.stall);
            chk("ForwardAD",  hz.ForwardAD,  e.fad);
            chk("ForwardBD",  hz.ForwardBD,  e.fbd);
            chk("ForwardAE",  hz.ForwardAE,  e.fae);
            chk("ForwardBE",  hz.ForwardBE,  e.fbe);
            chk("MdBusy",     hz.MdBusy,     e.busy);
            chk("StallCount", hz.StallCount, e.cnt);
            if (hz.StallD === 1'b1) stall_seen++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;

        // Hazards present while in reset: everything must stay quiet
        hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.WriteRegE = 9; hz.RtD = 9;
        hz.RegWriteM = 1; hz.WriteRegM = 8; hz.RsE = 8; hz.MdStartE = 1; hz.MdUseD = 1;
        step();
        reset = 1'b0;
        clear_inputs();
        step();

        // Forwarding priority
        hz.RegWriteM = 1; hz.WriteRegM = 8; hz.RegWriteW = 1; hz.WriteRegW = 8; hz.RsE = 8; hz.RtE = 0;
        step();
        hz.RegWriteM = 0;
        step();

        // Load-use
        clear_inputs();
        hz.MemtoRegE = 1; hz.RegWriteE = 1; hz.WriteRegE = 9; hz.RtD = 9;
        step();
        hz.WriteRegE = 0;
        step();

        // Branch then JR against an ALU result moving from E to M
        for (int k = 0; k < 2; k++) begin
            clear_inputs();
            hz.BranchD = (k == 0); hz.JrD = (k == 1);
            hz.RegWriteE = 1; hz.WriteRegE = 3; hz.RsD = 3;
            step();
            hz.RegWriteE = 0; hz.WriteRegE = 0; hz.RegWriteM = 1; hz.WriteRegM = 3;
            step();
        end

        // Multiply and divide latency as seen through StallD
        for (int k = 0; k < 2; k++) begin
            clear_inputs();
            stall_seen = 0;
            hz.MdStartE = 1; hz.MdDivE = (k == 1); hz.MdUseD = 1;
            step();
            hz.MdStartE = 0;
            repeat ((k == 1 ? DIV_LAT : MULT_LAT) + 3) step();
            chk(k == 1 ? "div_stall_cycles" : "mult_stall_cycles", stall_seen,
                (k == 1 ? DIV_LAT : MULT_LAT) + 1);
        end

        // Reset with a multiply in flight
        clear_inputs();
        hz.ClrCount = 1;
        step();
        hz.ClrCount = 0; hz.MdStartE = 1; hz.MdUseD = 1;
        step();
        hz.MdStartE = 0;
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("busy_after_reset", hz.MdBusy, 0);
        chk("count_after_reset", hz.StallCount, 0);
        step();

        // Counter saturation and clear priority
        clear_inputs();
        hz.ClrCount = 1;
        step();
        hz.ClrCount = 0; hz.MemtoRegE = 1; hz.WriteRegE = 9; hz.RtD = 9;
        repeat (20) step();
        chk("count_saturated", hz.StallCount, CNT_MAX);
        hz.ClrCount = 1;
        step();
        chk("clear_over_incr", hz.StallCount, 0);

        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 63) == 0);
            hz.BranchD   = ($urandom_range(0, 3) == 0);
            hz.JrD       = ($urandom_range(0, 5) == 0);
            hz.RsD       = rreg(); hz.RtD = rreg();
            hz.RsE       = rreg(); hz.RtE = rreg();
            hz.WriteRegE = rreg(); hz.WriteRegM = rreg(); hz.WriteRegW = rreg();
            hz.MemtoRegE = ($urandom_range(0, 3) == 0);
            hz.RegWriteE = $urandom_range(0, 1);
            hz.MemtoRegM = ($urandom_range(0, 3) == 0);
            hz.RegWriteM = $urandom_range(0, 1);
            hz.RegWriteW = $urandom_range(0, 1);
            hz.MdStartE  = ($urandom_range(0, 15) == 0);
            hz.MdDivE    = ($urandom_range(0, 3) == 0);
            hz.MdUseD    = $urandom_range(0, 1);
            hz.ClrCount  = ($urandom_range(0, 31) == 0);
            step();
        end

        reset = 1'b0;
        clear_inputs();
        repeat (3) step();
        repeat (2) @(posedge clk);
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
